// File: rtl/alu_sched_pkg.sv
// alu_sched_pkg
// Shared types and constants for the ALU request scheduler.
//   state_e : scheduler FSM states
//   rsp_t   : captured response (result, {C,N,Z,V} flags, timeout marker)
//   FLAG_*  : bit positions of the CNZV flags inside a 4-bit flag word
package alu_sched_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_e;

   localparam int FLAG_C = 3;
   localparam int FLAG_N = 2;
   localparam int FLAG_Z = 1;
   localparam int FLAG_V = 0;

   localparam int DEF_OPW     = 4;
   localparam int DEF_TIMEOUT = 16;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  flags;
      logic        timeout;
   } rsp_t;

endpackage

// File: rtl/alu_req_sched_rr_pick.sv
// rr_pick
// Combinational round-robin selector: returns the first set request bit at
// or after ptr_i, wrapping modulo NREQ.
//   req_i   : request vector
//   ptr_i   : highest-priority index for this pick
//   found_o : at least one request is set
//   win_o   : one-hot winner (zero when no request)
//   idx_o   : index of the winner (zero when no request)
module rr_pick #(
   parameter int NREQ = 4,
   parameter int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [PTRW-1:0] ptr_i,
   output logic            found_o,
   output logic [NREQ-1:0] win_o,
   output logic [PTRW-1:0] idx_o
);

   int j;

   always_comb begin
      found_o = 1'b0;
      win_o   = '0;
      idx_o   = '0;
      j       = 0;
      // Scan NREQ positions starting at ptr; the first hit wins.
      for (int k = 0; k < NREQ; k++) begin
         j = (int'(ptr_i) + k) % NREQ;
         if (!found_o && req_i[j]) begin
            found_o  = 1'b1;
            win_o[j] = 1'b1;
            idx_o    = PTRW'(j);
         end
      end
   end

endmodule

// File: rtl/alu_req_sched.sv
// alu_req_sched
// Round-robin scheduler sharing one 32-bit ALU between NREQ requesters.
// A winner is picked in IDLE, its opcode/operands are latched and issued
// with a one-cycle start strobe, then the scheduler waits (bounded by
// TIMEOUT cycles) for the ALU ack and returns result + CNZV flags with a
// one-cycle one-hot rsp_valid.
//   clk_i, rst_i        : clock, synchronous active-high reset
//   req_i/req_op_i/...  : per-requester request level, opcode and operands
//   gnt_o               : one-hot grant, ISSUE through RESP
//   rsp_valid_o         : one-hot result strobe (RESP)
//   rsp_data_o/flags_o  : result and {C,N,Z,V}, held until next RESP
//   rsp_timeout_o       : response was produced by timeout, not ack
//   busy_o              : FSM not in IDLE
//   alu_start_o/op/a/b  : issue interface to the ALU
//   alu_out_i/ack_i/flags_i : completion interface from the ALU
module alu_req_sched
   import alu_sched_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int OPW     = DEF_OPW,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [NREQ-1:0]     req_i,
   input  logic [NREQ*OPW-1:0] req_op_i,
   input  logic [NREQ*32-1:0]  req_a_i,
   input  logic [NREQ*32-1:0]  req_b_i,
   output logic [NREQ-1:0]     gnt_o,
   output logic [NREQ-1:0]     rsp_valid_o,
   output logic [31:0]         rsp_data_o,
   output logic [3:0]          rsp_flags_o,
   output logic                rsp_timeout_o,
   output logic                busy_o,
   output logic                alu_start_o,
   output logic [OPW-1:0]      alu_op_o,
   output logic [31:0]         alu_a_o,
   output logic [31:0]         alu_b_o,
   input  logic [31:0]         alu_out_i,
   input  logic                alu_ack_i,
   input  logic [3:0]          alu_flags_i
);

   localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CNTW = $clog2(TIMEOUT);
   localparam logic [PTRW-1:0] W_LAST   = PTRW'(NREQ - 1);
   localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT - 1);

   state_e            state_q, state_d;
   logic [PTRW-1:0]   w_q, w_d;
   logic [NREQ-1:0]   woh_q, woh_d;
   logic [PTRW-1:0]   ptr_q, ptr_d;
   logic [CNTW-1:0]   cnt_q, cnt_d;
   logic [OPW-1:0]    op_q, op_d;
   logic [31:0]       a_q, a_d;
   logic [31:0]       b_q, b_d;
   rsp_t              rsp_q, rsp_d;

   logic              pick_found;
   logic [NREQ-1:0]   pick_win;
   logic [PTRW-1:0]   pick_idx;

   rr_pick #(.NREQ(NREQ), .PTRW(PTRW)) u_pick (
      .req_i   (req_i),
      .ptr_i   (ptr_q),
      .found_o (pick_found),
      .win_o   (pick_win),
      .idx_o   (pick_idx)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         w_q     <= '0;
         woh_q   <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         rsp_q   <= '0;
      end else begin
         state_q <= state_d;
         w_q     <= w_d;
         woh_q   <= woh_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         rsp_q   <= rsp_d;
      end
   end

   always_comb begin
      state_d = state_q;
      w_d     = w_q;
      woh_d   = woh_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      rsp_d   = rsp_q;
      unique case (state_q)
         IDLE: begin
            // Operands are latched here so later requester-side changes
            // cannot disturb the in-flight operation.
            if (pick_found) begin
               w_d     = pick_idx;
               woh_d   = pick_win;
               op_d    = req_op_i[pick_idx*OPW +: OPW];
               a_d     = req_a_i[pick_idx*32 +: 32];
               b_d     = req_b_i[pick_idx*32 +: 32];
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            cnt_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            // Ack is tested first so an ack on the last allowed cycle wins.
            if (alu_ack_i) begin
               rsp_d   = '{data: alu_out_i, flags: alu_flags_i, timeout: 1'b0};
               state_d = RESP;
            end else if (cnt_q == CNT_LAST) begin
               rsp_d   = '{data: 32'd0, flags: 4'd0, timeout: 1'b1};
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RESP: begin
            ptr_d   = (w_q == W_LAST) ? '0 : w_q + 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign gnt_o         = (state_q != IDLE) ? woh_q : '0;
   assign rsp_valid_o   = (state_q == RESP) ? woh_q : '0;
   assign busy_o        = (state_q != IDLE);
   assign alu_start_o   = (state_q == ISSUE);
   assign alu_op_o      = op_q;
   assign alu_a_o       = a_q;
   assign alu_b_o       = b_q;
   assign rsp_data_o    = rsp_q.data;
   assign rsp_flags_o   = rsp_q.flags;
   assign rsp_timeout_o = rsp_q.timeout;

endmodule
